// File: rtl/fetch_unit.sv
// fetch_unit: ROM address generation, PC tagging and prefetch FIFO.
// Optional macro FETCH_BYPASS_EN: forward the returning ROM word when the FIFO is empty.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic              bypass;
  logic              pop;
  logic              fifo_pop;
  logic              push;
  logic              issue;
  logic [CW:0]       credit;

  assign rom_address = pc;

`ifdef FETCH_BYPASS_EN
  assign bypass = (count == '0) && inflight;
`else
  assign bypass = 1'b0;
`endif

  // Present the FIFO head, the bypassed ROM word, or zeros when empty
  always_comb begin
    instr_valid = 1'b0;
    instr       = '0;
    instr_pc    = '0;
    if (count != '0) begin
      instr_valid = 1'b1;
      instr       = data_mem[rd_ptr];
      instr_pc    = pc_mem[rd_ptr];
    end else if (bypass) begin
      instr_valid = 1'b1;
      instr       = rom_q;
      instr_pc    = inflight_pc;
    end
  end

  assign pop      = instr_valid && instr_ready;
  assign fifo_pop = pop && (count != '0);
  assign push     = inflight && !redirect_valid
                    && !(bypass && instr_ready);

  // Reserve a slot for every read in flight so the FIFO never overflows
  assign credit = {1'b0, count}
                + (CW+1)'(inflight)
                - (CW+1)'(pop);
  assign issue  = !redirect_valid
                && (credit < (CW+1)'(DEPTH));

  // PC, in-flight tag and FIFO bookkeeping; redirect flushes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + 1'b1;
        inflight_pc <= pc;
      end
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(fifo_pop);
    end
  end

  // FIFO payload storage; validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= rom_q;
      pc_mem[wr_ptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit
// against a PC-sequence scoreboard and a modelled ROM.
module tb_fetch_unit;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rom_address;
  logic [15:0] rom_q;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;

  int          checks = 0;
  int          fails  = 0;
  logic [15:0] exp_pc;

  fetch_unit #(
    .ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rom_address(rom_address),
    .rom_q(rom_q),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] romv(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // Synchronous ROM: one-cycle read latency
  always @(posedge clk) rom_q <= romv(rom_address);

  task automatic test_reset();
    rst = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #1;
    checks++;
    if ({instr_valid, instr, instr_pc, rom_address} !== 49'h0) begin
      fails++;
      $display("FAIL reset_state: got v=%b i=%h pc=%h a=%h want all zero",
               instr_valid, instr, instr_pc, rom_address);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (rom_address !== 16'(c)) begin
        fails++;
        $display("FAIL stream_addr c%0d: got %h want %h", c, rom_address, 16'(c));
      end
      checks++;
      if (c < LAT) begin
        if (instr_valid !== 1'b0) begin
          fails++;
          $display("FAIL stream_early c%0d: got valid %b want 0", c, instr_valid);
        end
      end else if (!(instr_valid === 1'b1 && instr_pc === 16'(c - LAT)
                     && instr === romv(16'(c - LAT)))) begin
        fails++;
        $display("FAIL stream_word c%0d: got v=%b pc=%h i=%h want pc=%h i=%h",
                 c, instr_valid, instr_pc, instr, 16'(c - LAT), romv(16'(c - LAT)));
      end
      @(negedge clk);
    end
    exp_pc = 16'(10 - LAT);
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (!(instr_valid === 1'b1 && instr_pc === exp_pc)) begin
        fails++;
        $display("FAIL stall_hold k%0d: got v=%b pc=%h want pc=%h",
                 k, instr_valid, instr_pc, exp_pc);
      end
      if (k == 9) begin
        checks++;
        if (rom_address !== exp_pc + 16'(DEPTH)) begin
          fails++;
          $display("FAIL stall_full: got addr %h want %h",
                   rom_address, exp_pc + 16'(DEPTH));
        end
      end
      @(negedge clk);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      checks++;
      if (!(instr_valid === 1'b1 && instr_pc === exp_pc
            && instr === romv(exp_pc))) begin
        fails++;
        $display("FAIL stall_resume k%0d: got v=%b pc=%h i=%h want pc=%h",
                 k, instr_valid, instr_pc, instr, exp_pc);
      end
      exp_pc++;
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_full();
    instr_ready = 1'b0;
    repeat (8) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    #1;
    checks++;
    if (!(instr_valid === 1'b1 && instr_pc === exp_pc)) begin
      fails++;
      $display("FAIL redir_full_c0: got v=%b pc=%h want pc=%h",
               instr_valid, instr_pc, exp_pc);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    for (int c = 1; c <= LAT + 4; c++) begin
      #1;
      if (c == 1) begin
        checks++;
        if (rom_address !== 16'h0100) begin
          fails++;
          $display("FAIL redir_addr: got %h want 0100", rom_address);
        end
      end
      checks++;
      if (c <= LAT) begin
        if (instr_valid !== 1'b0) begin
          fails++;
          $display("FAIL redir_stale c%0d: got v=%b pc=%h want invalid",
                   c, instr_valid, instr_pc);
        end
      end else if (!(instr_valid === 1'b1
                     && instr_pc === 16'h0100 + 16'(c - LAT - 1)
                     && instr === romv(16'h0100 + 16'(c - LAT - 1)))) begin
        fails++;
        $display("FAIL redir_word c%0d: got v=%b pc=%h i=%h want pc=%h",
                 c, instr_valid, instr_pc, instr, 16'h0100 + 16'(c - LAT - 1));
      end
      @(negedge clk);
    end
    exp_pc = 16'h0104;
  endtask

  task automatic test_redirect_pop();
    int n;
    n = 0;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0200;
    #1;
    checks++;
    if (!(instr_valid === 1'b1 && instr_pc === exp_pc)) begin
      fails++;
      $display("FAIL redir_pop_word: got v=%b pc=%h want pc=%h",
               instr_valid, instr_pc, exp_pc);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_pc = 16'h0200;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (instr_valid === 1'b1) begin
        checks++;
        if (instr_pc !== exp_pc || instr !== romv(exp_pc)) begin
          fails++;
          $display("FAIL redir_pop_seq c%0d: got pc=%h i=%h want pc=%h",
                   c, instr_pc, instr, exp_pc);
        end
        exp_pc++;
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 10 - LAT) begin
      fails++;
      $display("FAIL redir_pop_count: got %0d words want %0d", n, 10 - LAT);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want [4];
    int n;
    want[0] = 16'hFFFE;
    want[1] = 16'hFFFF;
    want[2] = 16'h0000;
    want[3] = 16'h0001;
    n = 0;
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    for (int c = 0; c < 20 && n < 4; c++) begin
      #1;
      if (instr_valid === 1'b1) begin
        checks++;
        if (instr_pc !== want[n] || instr !== romv(want[n])) begin
          fails++;
          $display("FAIL wrap_%0d: got pc=%h i=%h want pc=%h",
                   n, instr_pc, instr, want[n]);
        end
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 4) begin
      fails++;
      $display("FAIL wrap_timeout: got %0d words want 4", n);
    end
    exp_pc = 16'h0002;
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (!(instr_valid === 1'b1 && instr_pc === 16'h0300
          && rom_address === 16'h0304)) begin
      fails++;
      $display("FAIL mid_setup: got v=%b pc=%h a=%h want pc=0300 a=0304",
               instr_valid, instr_pc, rom_address);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({instr_valid, instr, instr_pc, rom_address} !== 49'h0) begin
      fails++;
      $display("FAIL mid_reset: got v=%b i=%h pc=%h a=%h want all zero",
               instr_valid, instr, instr_pc, rom_address);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    instr_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (c < LAT) begin
        if (instr_valid !== 1'b0) begin
          fails++;
          $display("FAIL mid_restart_early c%0d: got valid %b want 0",
                   c, instr_valid);
        end
      end else if (!(instr_valid === 1'b1 && instr_pc === 16'(c - LAT))) begin
        fails++;
        $display("FAIL mid_restart c%0d: got v=%b pc=%h want pc=%h",
                 c, instr_valid, instr_pc, 16'(c - LAT));
      end
      @(negedge clk);
    end
    exp_pc = 16'(6 - LAT);
  endtask

  task automatic test_random();
    logic        rd;
    logic [15:0] tgt;
    bit          seen;
    for (int c = 0; c < 400; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 15) == 0);
      tgt = 16'($urandom);
      redirect_valid = rd;
      redirect_pc = tgt;
      #1;
      checks++;
      if (instr_valid === 1'b1) begin
        if (instr_ready && (instr_pc !== exp_pc || instr !== romv(exp_pc))) begin
          fails++;
          $display("FAIL rand_word c%0d: got pc=%h i=%h want pc=%h i=%h",
                   c, instr_pc, instr, exp_pc, romv(exp_pc));
        end
        if (instr_ready) exp_pc++;
      end else if (instr_valid !== 1'b0 || instr !== '0 || instr_pc !== '0) begin
        fails++;
        $display("FAIL rand_idle c%0d: got v=%b i=%h pc=%h want zeros",
                 c, instr_valid, instr, instr_pc);
      end
      if (rd) exp_pc = tgt;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (instr_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (instr_pc !== exp_pc) begin
          fails++;
          $display("FAIL rand_drain: got pc=%h want %h", instr_pc, exp_pc);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL rand_liveness: no valid word within 10 cycles");
    end
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    exp_pc = '0;
    @(negedge clk);
    test_reset();
    test_stall();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction ROM. It generates the 16-bit ROM address, accounts for the ROM's one-cycle synchronous read latency, and tags each returning word with its PC. Words are buffered in a small prefetch FIFO and handed to decode over a valid/ready handshake. Branch/jump redirects flush the buffer and any in-flight read.

## Interface
- ADDR_W, 16, ROM address / PC width
- DATA_W, 16, instruction word width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥ 2
- RESET_PC, 16'h0000, first fetch address after reset
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rom_address  out  ADDR_W  address to ROM; equals pc register
- rom_q  in  DATA_W  ROM read data; valid the cycle after the address is captured
- redirect_valid  in  1  load new PC this cycle; flush
- redirect_pc  in  ADDR_W  redirect target
- instr_valid  out  1  instr/instr_pc hold a fetched word
- instr_ready  in  1  downstream accepts when instr_valid & instr_ready
- instr  out  DATA_W  instruction word at FIFO head
- instr_pc  out  ADDR_W  address of instr

## Operation
- State: pc, inflight bit, inflight_pc, FIFO (wr/rd pointers, count 0..DEPTH).
- ROM samples rom_address at every edge; a cycle is an issue only when tagged: issue = !redirect_valid & (count + inflight - pop < DEPTH), pop = instr_valid & instr_ready.
- On issue: pc <= pc + 1 (mod 2^ADDR_W, 16'hFFFF -> 16'h0000), inflight <= 1, inflight_pc <= pc. Otherwise pc holds and inflight <= 0.
- When inflight = 1 (and no redirect): FIFO write {rom_q, inflight_pc} at the edge. Simultaneous push and pop allowed at any count; credit rule guarantees no overflow.
- Redirect (highest priority): pc <= redirect_pc, FIFO cleared (count 0, pointers 0), inflight <= 0, returning rom_q discarded. A pop in the same cycle is still a completed handshake for the word presented.
- instr_valid = (count != 0); instr/instr_pc = FIFO head, registered storage; outputs 0 when empty.
- Reset values: pc = RESET_PC, rom_address = RESET_PC, inflight 0, count 0, instr_valid 0, instr 0, instr_pc 0.

## Timing
- Cycle n issue (address A) -> rom_q(A) in n+1 -> written at end of n+1 -> instr_valid, instr_pc = A in n+2 (if FIFO was empty).
- Redirect in cycle 0 -> rom_address = target in cycle 1 -> instr_valid with instr_pc = target in cycle 3.
- Steady state with instr_ready held high: one instruction per cycle, consecutive PCs, no bubbles.
- instr_ready low: FIFO fills to DEPTH, issue stops; no word lost or duplicated; resumes one word/cycle on ready.
- Reset asserted mid-operation: all state returns to reset values immediately (async); first issue is the first cycle after deassertion.

## Configuration
- FETCH_BYPASS_EN defined: when count = 0 and inflight = 1, rom_q/inflight_pc drive instr/instr_pc combinationally with instr_valid = 1; if instr_ready is high the word is not written to the FIFO. Issue-to-valid latency 1 cycle; redirect-to-valid latency 2 cycles.
- Not defined: outputs come only from FIFO storage; latencies as under Timing.

## Test plan
- Reset, RESET_PC = 0, ROM holds mem[i] = i ^ 16'hA5A5, ready = 1 -> instr_valid first in cycle 2, instr_pc 0,1,2,3... one per cycle, instr = mem[pc].
- ready = 0 for 10 cycles after first valid -> exactly DEPTH words buffered, rom issue stops; ready = 1 -> PCs continue with no gap or repeat.
- redirect_valid with redirect_pc = 16'h0100 while FIFO full -> instr_valid low cycles 1–2, instr_pc = 16'h0100 in cycle 3, then 16'h0101...; no stale word emitted.
- redirect and pop in the same cycle -> popped word counted once, no post-redirect word with old PC.
- redirect_pc = 16'hFFFE -> instr_pc sequence FFFE, FFFF, 0000, 0001.
- Assert rst while inflight = 1 and count = 3 -> outputs zero immediately; after release, fetch restarts at RESET_PC.
